// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage (fixed priority) and the MDU.
// Optional starvation guard compiled in with `define REGFILE_ARB_STARVE_EN.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_addr,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        stall_wb,
   output logic        rf_en,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        err_collide
);

   // Handshake: an MDU result transfers in any cycle where mdu_valid & mdu_ready;
   // the MDU must hold valid/addr/data stable until that cycle. WB is never stalled here
   // except through the registered stall_wb bubble request.
   logic wb_sel;
   logic mdu_sel;

   assign wb_sel    = wb_en & ~reset;
   assign mdu_sel   = mdu_valid & ~wb_en & ~reset;
   assign mdu_ready = mdu_sel;

   always_comb begin
      rf_wa = 5'd0;
      rf_wd = 32'd0;
      if (wb_sel) begin
         rf_wa = wb_addr;
         rf_wd = wb_data;
      end else if (mdu_sel) begin
         rf_wa = mdu_addr;
         rf_wd = mdu_data;
      end
   end

   // $0 is hardwired; the MDU handshake still completes so its result is discarded.
   assign rf_en = (wb_sel | mdu_sel) & (rf_wa != 5'd0);

`ifdef REGFILE_ARB_STARVE_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (stall_wb & wb_en) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (mdu_valid & wb_en) begin
               state_nx = WAIT;
               cnt_nx   = CNT_W'(1);
            end
         end
         WAIT: begin
            if (~mdu_valid | ~wb_en) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == LIMIT) begin
               state_nx = FORCE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         FORCE: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Reset masks the bubble and the sticky flag in the cycle reset is asserted.
   assign stall_wb    = (state == FORCE) & ~reset;
   assign err_collide = err_q & ~reset;
`else
   logic unused_cfg;

   assign stall_wb    = 1'b0;
   assign err_collide = 1'b0;
   assign unused_cfg  = clk ^ (STARVE_LIMIT > 0) ^ (CNT_W > 0);
`endif

endmodule
